// File: rtl/prt_dp_lb_mbox_pkg.sv
// Shared constants and types for the local-bus mailbox.
// Holds the register word addresses, the CTL/STA bit positions and the CTL register struct.
package prt_dp_lb_mbox_pkg;

   // Register word addresses (only adr[1:0] is decoded)
   localparam logic [1:0] ADR_CTL   = 2'd0;
   localparam logic [1:0] ADR_STA   = 2'd1;
   localparam logic [1:0] ADR_TXDAT = 2'd2;
   localparam logic [1:0] ADR_RXDAT = 2'd3;

   // CTL bit positions
   localparam int unsigned CTL_RUN      = 0;
   localparam int unsigned CTL_TX_FLUSH = 1;
   localparam int unsigned CTL_RX_FLUSH = 2;
   localparam int unsigned CTL_IRQ_EN   = 3;

   // STA bit positions
   localparam int unsigned STA_TX_EMPTY   = 0;
   localparam int unsigned STA_TX_FULL    = 1;
   localparam int unsigned STA_RX_EMPTY   = 2;
   localparam int unsigned STA_RX_FULL    = 3;
   localparam int unsigned STA_IRQ        = 4;
   localparam int unsigned STA_TX_OVF     = 5;
   localparam int unsigned STA_TX_CNT_LSB = 8;
   localparam int unsigned STA_RX_CNT_LSB = 16;

   // CTL register; the flush fields are pulses and are never stored as 1.
   typedef struct packed {
      logic irq_en;
      logic rx_flush;
      logic tx_flush;
      logic run;
   } ctl_t;

endpackage

// File: rtl/prt_dp_lb_if.sv
// Local bus link between the bus mux and one responder.
//   adr/din/wr/rd : request from the mux
//   dout/vld      : registered read response from the responder
interface prt_dp_lb_if;
   logic [15:0] adr;
   logic [31:0] din;
   logic [31:0] dout;
   logic        wr;
   logic        rd;
   logic        vld;

   modport lb_in  (input adr, din, wr, rd, output dout, vld);
   modport lb_out (output adr, din, wr, rd, input dout, vld);
endinterface

// File: rtl/prt_dp_lb_mbox_fifo.sv
// Single-clock first-word-fall-through FIFO of 32-bit words.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   flush_i           : clear contents; wins over a push or pop in the same cycle
//   push_i/push_dat_i : write request; accepted when not full or when a pop frees space
//   pop_i             : remove head; ignored when empty
//   head_o            : current head word (valid when !empty_o)
//   empty_o, full_o   : status
//   cnt_o             : number of stored words
module prt_dp_lb_mbox_fifo #(
   parameter int unsigned Depth = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [31:0]              push_dat_i,
   input  logic                     pop_i,
   output logic [31:0]              head_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(Depth):0]   cnt_o
);

   localparam int unsigned AW = $clog2(Depth);
   localparam int unsigned DepthW = Depth;
   localparam logic [AW:0] FullCnt = DepthW[AW:0];

   logic [31:0]   mem_q [Depth];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop, mem_we;

   always_comb begin
      do_pop   = pop_i & (cnt_q != '0);
      // a simultaneous pop makes room, so a push at full is still taken
      do_push  = push_i & ((cnt_q != FullCnt) | do_pop);
      mem_we   = do_push & ~flush_i;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
         else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // storage needs no reset: pointers decide what is visible
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == FullCnt);
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/prt_dp_lb_mbox.sv
// Local-bus mailbox between the CPU and a hardware stream agent.
//   CLK_IN, RST_IN        : clock, synchronous active-high reset
//   LB_IF                 : local bus responder port (registered 1-cycle read response)
//   TX_DAT/VLD_OUT, TX_RDY_IN : TX stream fed from CPU writes to TXDAT
//   RX_DAT/VLD_IN, RX_RDY_OUT : RX stream popped by CPU reads of RXDAT
//   IRQ_OUT               : registered level interrupt, IRQ_EN and RX not empty
module prt_dp_lb_mbox
   import prt_dp_lb_mbox_pkg::*;
#(
   parameter int unsigned P_FIFO_WRDS = 16,
   parameter int unsigned P_SIM       = 0
) (
   input  logic          CLK_IN,
   input  logic          RST_IN,
   prt_dp_lb_if.lb_in    LB_IF,
   output logic [31:0]   TX_DAT_OUT,
   output logic          TX_VLD_OUT,
   input  logic          TX_RDY_IN,
   input  logic [31:0]   RX_DAT_IN,
   input  logic          RX_VLD_IN,
   output logic          RX_RDY_OUT,
   output logic          IRQ_OUT
);

   localparam int unsigned CW = $clog2(P_FIFO_WRDS) + 1;

   if (P_SIM != 0) begin : g_sim
   end

   ctl_t        ctl_q, ctl_d;
   logic        tx_ovf_q, tx_ovf_d;
   logic        irq_q, irq_d;
   logic        rd_vld_q, rd_vld_d;
   logic [31:0] rd_dat_q, rd_dat_d;

   logic [1:0]    reg_adr;
   logic          rd_en;
   logic          wr_ctl, wr_sta, wr_txdat;
   logic          tx_flush, rx_flush;
   logic          tx_push, tx_pop, rx_push, rx_pop;
   logic [31:0]   tx_head, rx_head;
   logic          tx_empty, tx_full, rx_empty, rx_full;
   logic [CW-1:0] tx_cnt, rx_cnt;
   logic [31:0]   sta;
   logic          unused_adr;

   assign unused_adr = ^LB_IF.adr[15:2];
   assign reg_adr    = LB_IF.adr[1:0];

   always_comb begin
      // a write wins over a read presented in the same cycle
      rd_en    = LB_IF.rd & ~LB_IF.wr;
      wr_ctl   = LB_IF.wr & (reg_adr == ADR_CTL);
      wr_sta   = LB_IF.wr & (reg_adr == ADR_STA);
      wr_txdat = LB_IF.wr & (reg_adr == ADR_TXDAT);
      tx_flush = wr_ctl & LB_IF.din[CTL_TX_FLUSH];
      rx_flush = wr_ctl & LB_IF.din[CTL_RX_FLUSH];
      tx_push  = wr_txdat;
      tx_pop   = TX_VLD_OUT & TX_RDY_IN;
      rx_push  = RX_VLD_IN & RX_RDY_OUT;
      rx_pop   = rd_en & (reg_adr == ADR_RXDAT) & ~rx_empty;
   end

   prt_dp_lb_mbox_fifo #(
      .Depth (P_FIFO_WRDS)
   ) u_tx_fifo (
      .clk_i      (CLK_IN),
      .rst_i      (RST_IN),
      .flush_i    (tx_flush),
      .push_i     (tx_push),
      .push_dat_i (LB_IF.din),
      .pop_i      (tx_pop),
      .head_o     (tx_head),
      .empty_o    (tx_empty),
      .full_o     (tx_full),
      .cnt_o      (tx_cnt)
   );

   prt_dp_lb_mbox_fifo #(
      .Depth (P_FIFO_WRDS)
   ) u_rx_fifo (
      .clk_i      (CLK_IN),
      .rst_i      (RST_IN),
      .flush_i    (rx_flush),
      .push_i     (rx_push),
      .push_dat_i (RX_DAT_IN),
      .pop_i      (rx_pop),
      .head_o     (rx_head),
      .empty_o    (rx_empty),
      .full_o     (rx_full),
      .cnt_o      (rx_cnt)
   );

   always_comb begin
      sta                                   = '0;
      sta[STA_TX_EMPTY]                     = tx_empty;
      sta[STA_TX_FULL]                      = tx_full;
      sta[STA_RX_EMPTY]                     = rx_empty;
      sta[STA_RX_FULL]                      = rx_full;
      sta[STA_IRQ]                          = irq_q;
      sta[STA_TX_OVF]                       = tx_ovf_q;
      sta[STA_TX_CNT_LSB +: 8]              = 8'(tx_cnt);
      sta[STA_RX_CNT_LSB +: 8]              = 8'(rx_cnt);
   end

   always_comb begin
      ctl_d          = ctl_q;
      ctl_d.tx_flush = 1'b0;
      ctl_d.rx_flush = 1'b0;
      if (wr_ctl) begin
         ctl_d.run    = LB_IF.din[CTL_RUN];
         ctl_d.irq_en = LB_IF.din[CTL_IRQ_EN];
      end

      tx_ovf_d = tx_ovf_q;
      if (wr_sta && LB_IF.din[STA_TX_OVF]) tx_ovf_d = 1'b0;
      // dropped only when full and no pop frees a slot this cycle
      if (tx_push && tx_full && !tx_pop)   tx_ovf_d = 1'b1;

      irq_d = ctl_q.irq_en & ~rx_empty;

      rd_vld_d = rd_en;
      rd_dat_d = '0;
      if (rd_en) begin
         case (reg_adr)
            ADR_CTL:   rd_dat_d = 32'(ctl_q);
            ADR_STA:   rd_dat_d = sta;
            ADR_RXDAT: rd_dat_d = rx_empty ? 32'd0 : rx_head;
            default:   rd_dat_d = '0;
         endcase
      end
   end

   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         ctl_q    <= '0;
         tx_ovf_q <= 1'b0;
         irq_q    <= 1'b0;
         rd_vld_q <= 1'b0;
         rd_dat_q <= '0;
      end else begin
         ctl_q    <= ctl_d;
         tx_ovf_q <= tx_ovf_d;
         irq_q    <= irq_d;
         rd_vld_q <= rd_vld_d;
         rd_dat_q <= rd_dat_d;
      end
   end

   assign LB_IF.vld  = rd_vld_q;
   assign LB_IF.dout = rd_dat_q;
   assign TX_DAT_OUT = tx_head;
   assign TX_VLD_OUT = ctl_q.run & ~tx_empty;
   assign RX_RDY_OUT = ctl_q.run & ~rx_full;
   assign IRQ_OUT    = irq_q;

endmodule

// File: tb/tb_prt_dp_lb_mbox.sv
module tb_prt_dp_lb_mbox;

   logic        clk;
   logic        rst;
   logic [31:0] tx_dat;
   logic        tx_vld;
   logic        tx_rdy;
   logic [31:0] rx_dat;
   logic        rx_vld;
   logic        rx_rdy;
   logic        irq;

   int n_chk;
   int n_err;

   logic [31:0] rd_exp_q [$];
   logic [31:0] tx_exp_q [$];
   logic        pend_q;

   prt_dp_lb_if lb_if ();

   prt_dp_lb_mbox #(
      .P_FIFO_WRDS (16),
      .P_SIM       (1)
   ) dut (
      .CLK_IN     (clk),
      .RST_IN     (rst),
      .LB_IF      (lb_if),
      .TX_DAT_OUT (tx_dat),
      .TX_VLD_OUT (tx_vld),
      .TX_RDY_IN  (tx_rdy),
      .RX_DAT_IN  (rx_dat),
      .RX_VLD_IN  (rx_vld),
      .RX_RDY_OUT (rx_rdy),
      .IRQ_OUT    (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   // Monitor: checks read response timing/data and TX stream data mid-cycle.
   initial pend_q = 1'b0;
   always @(negedge clk) begin
      logic [31:0] e;
      if (pend_q || lb_if.vld !== 1'b0) begin
         n_chk++;
         if (lb_if.vld !== pend_q) begin
            n_err++;
            $display("FAIL rd_vld act=%b exp=%b t=%0t", lb_if.vld, pend_q, $time);
         end
      end
      if (lb_if.vld === 1'b1) begin
         n_chk++;
         if (rd_exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rd_unexpected act=%h exp=none t=%0t", lb_if.dout, $time);
         end else begin
            e = rd_exp_q.pop_front();
            if (lb_if.dout !== e) begin
               n_err++;
               $display("FAIL rd_dout act=%h exp=%h t=%0t", lb_if.dout, e, $time);
            end
         end
      end else if (lb_if.dout !== 32'd0) begin
         n_chk++;
         n_err++;
         $display("FAIL dout_idle act=%h exp=00000000 t=%0t", lb_if.dout, $time);
      end
      pend_q = lb_if.rd & ~lb_if.wr & ~rst;

      if (tx_vld === 1'b1 && tx_rdy) begin
         n_chk++;
         if (tx_exp_q.size() == 0) begin
            n_err++;
            $display("FAIL tx_unexpected act=%h exp=none t=%0t", tx_dat, $time);
         end else begin
            e = tx_exp_q.pop_front();
            if (tx_dat !== e) begin
               n_err++;
               $display("FAIL tx_dat act=%h exp=%h t=%0t", tx_dat, e, $time);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic lb_wr(input logic [1:0] a, input logic [31:0] d);
      lb_if.adr = {14'd0, a};
      lb_if.din = d;
      lb_if.wr  = 1'b1;
      cyc();
      lb_if.wr  = 1'b0;
   endtask

   task automatic lb_rd(input logic [1:0] a, input logic [31:0] exp);
      rd_exp_q.push_back(exp);
      lb_if.adr = {14'd0, a};
      lb_if.rd  = 1'b1;
      cyc();
      lb_if.rd  = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      lb_if.adr = '0;
      lb_if.din = '0;
      lb_if.wr  = 1'b0;
      lb_if.rd  = 1'b0;
      tx_rdy = 1'b0;
      rx_dat = '0;
      rx_vld = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;

      // reset state
      chk("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
      chk("rst_rx_rdy", {31'd0, rx_rdy}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      lb_rd(2'd1, 32'h0000_0005);

      // TX basic
      lb_wr(2'd0, 32'h1);
      for (int i = 1; i <= 3; i++) lb_wr(2'd2, 32'hA5A5_0000 + 32'(i));
      chk("tx_vld_hold", {31'd0, tx_vld}, 32'd1);
      chk("tx_dat_head", tx_dat, 32'hA5A5_0001);
      lb_rd(2'd1, 32'h0000_0304);
      for (int i = 1; i <= 3; i++) tx_exp_q.push_back(32'hA5A5_0000 + 32'(i));
      tx_rdy = 1'b1;
      repeat (3) cyc();
      tx_rdy = 1'b0;
      chk("tx_vld_drained", {31'd0, tx_vld}, 32'd0);
      lb_rd(2'd1, 32'h0000_0005);

      // TX overflow
      lb_wr(2'd0, 32'h0);
      for (int i = 0; i < 17; i++) lb_wr(2'd2, 32'h100 + 32'(i));
      lb_rd(2'd1, 32'h0000_1026);
      chk("tx_vld_norun", {31'd0, tx_vld}, 32'd0);
      lb_wr(2'd1, 32'h20);
      lb_rd(2'd1, 32'h0000_1006);
      lb_wr(2'd0, 32'h1);
      for (int i = 0; i < 16; i++) tx_exp_q.push_back(32'h100 + 32'(i));
      tx_rdy = 1'b1;
      repeat (17) cyc();
      tx_rdy = 1'b0;

      // RX and IRQ
      lb_wr(2'd0, 32'h9);
      rx_dat = 32'h1234_5678;
      rx_vld = 1'b1;
      cyc();
      rx_vld = 1'b0;
      chk("irq_lag", {31'd0, irq}, 32'd0);
      cyc();
      chk("irq_rise", {31'd0, irq}, 32'd1);
      lb_rd(2'd3, 32'h1234_5678);
      chk("irq_hold", {31'd0, irq}, 32'd1);
      lb_rd(2'd3, 32'h0);
      chk("irq_fall", {31'd0, irq}, 32'd0);
      lb_rd(2'd1, 32'h0000_0005);

      // RX fill, pop at full, flush
      for (int i = 0; i < 16; i++) begin
         rx_dat = 32'h200 + 32'(i);
         rx_vld = 1'b1;
         cyc();
      end
      chk("rx_rdy_full", {31'd0, rx_rdy}, 32'd0);
      rx_dat = 32'h210;
      lb_rd(2'd1, 32'h0010_0019);
      lb_rd(2'd3, 32'h200);
      chk("rx_rdy_freed", {31'd0, rx_rdy}, 32'd1);
      cyc();
      rx_vld = 1'b0;
      chk("rx_rdy_refull", {31'd0, rx_rdy}, 32'd0);
      lb_rd(2'd1, 32'h0010_0019);
      lb_rd(2'd3, 32'h201);
      lb_wr(2'd0, 32'h5);
      lb_rd(2'd1, 32'h0000_0015);
      lb_rd(2'd1, 32'h0000_0005);

      // reset mid-transfer with a read in flight
      lb_wr(2'd0, 32'h1);
      for (int i = 0; i < 5; i++) lb_wr(2'd2, 32'h300 + 32'(i));
      chk("tx_vld_pre_rst", {31'd0, tx_vld}, 32'd1);
      rst = 1'b1;
      lb_if.adr = 16'd1;
      lb_if.rd  = 1'b1;
      cyc();
      rst = 1'b0;
      lb_if.rd  = 1'b0;
      chk("rst_tx_vld2", {31'd0, tx_vld}, 32'd0);
      chk("rst_rx_rdy2", {31'd0, rx_rdy}, 32'd0);
      chk("rst_irq2", {31'd0, irq}, 32'd0);

      // wr and rd together: write only, no response
      lb_if.adr = 16'd0;
      lb_if.din = 32'h0;
      lb_if.wr  = 1'b1;
      lb_if.rd  = 1'b1;
      cyc();
      lb_if.wr  = 1'b0;
      lb_if.rd  = 1'b0;
      lb_rd(2'd1, 32'h0000_0005);
      lb_rd(2'd0, 32'h0000_0000);

      repeat (3) cyc();
      chk("rd_q_drain", 32'(rd_exp_q.size()), 32'd0);
      chk("tx_q_drain", 32'(tx_exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
